// File: rtl/tag_stream_compactor.sv
// tag_stream_compactor
//
// Filters a wide tag-event stream with per-channel/per-edge enable masks and
// repacks surviving events into dense words (kept lanes contiguous from lane 0),
// preserving arrival order. A partial word is emitted after FLUSH_CYCLES idle
// cycles (0 holds partial words indefinitely).
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   s_axis_tvalid/tready  input word handshake
//   s_axis_tagtime        64 bits per lane, 1/3 ps units
//   s_axis_channel        5 bits per lane, zero-based channel
//   s_axis_rising_edge    1 bit per lane, 1 = rising
//   s_axis_tkeep          per-lane event valid
//   rising_mask           bit c keeps rising events of channel c
//   falling_mask          bit c keeps falling events of channel c
//   m_axis_*              compacted output word and handshake
//   kept_events           wrapping count of events that passed the filter
module tag_stream_compactor #(
    parameter int unsigned WORD_WIDTH   = 4,
    parameter int unsigned FLUSH_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [64*WORD_WIDTH-1:0] s_axis_tagtime,
    input  logic [5*WORD_WIDTH-1:0]  s_axis_channel,
    input  logic [WORD_WIDTH-1:0]    s_axis_rising_edge,
    input  logic [WORD_WIDTH-1:0]    s_axis_tkeep,
    input  logic [31:0]              rising_mask,
    input  logic [31:0]              falling_mask,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [64*WORD_WIDTH-1:0] m_axis_tagtime,
    output logic [5*WORD_WIDTH-1:0]  m_axis_channel,
    output logic [WORD_WIDTH-1:0]    m_axis_rising_edge,
    output logic [WORD_WIDTH-1:0]    m_axis_tkeep,
    output logic [31:0]              kept_events
);

    localparam int unsigned W      = WORD_WIDTH;
    localparam int unsigned DEPTH  = 2 * WORD_WIDTH;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDLE_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    // Ordered buffer; entry 0 is the oldest event and maps to output lane 0.
    logic [63:0]       r_tag  [DEPTH];
    logic [4:0]        r_ch   [DEPTH];
    logic              r_rise [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_flush;
    logic [IDLE_W-1:0] r_idle;
    logic [31:0]       r_kept_events;

    logic [63:0]       w_tag_d  [DEPTH];
    logic [4:0]        w_ch_d   [DEPTH];
    logic              w_rise_d [DEPTH];
    logic [W-1:0]      w_kept;
    logic [CNT_W-1:0]  w_n_kept;
    logic [CNT_W-1:0]  w_n_pop;
    logic [CNT_W-1:0]  w_base;
    logic [CNT_W-1:0]  w_count_d;
    logic [IDLE_W-1:0] w_idle_d;
    logic              w_flush_d;
    logic              w_m_valid;
    logic              w_s_ready;
    logic              w_accept;
    logic              w_pop;
    logic              w_append;
    logic              w_idle_run;

    // Ready depends only on registered state (and reset), never on m_axis_tready.
    assign w_s_ready = rst_n & (r_count <= CNT_W'(W)) & ~r_flush;
    assign w_m_valid = (r_count >= CNT_W'(W)) | r_flush;
    assign w_accept  = s_axis_tvalid & w_s_ready;
    assign w_pop     = w_m_valid & m_axis_tready;
    assign w_append  = w_accept & (|w_kept);

    // Lane filter and kept-lane population count.
    always_comb begin
        w_kept   = '0;
        w_n_kept = '0;
        for (int unsigned i = 0; i < W; i++) begin
            w_kept[i] = s_axis_tkeep[i] &
                        (s_axis_rising_edge[i] ? rising_mask[s_axis_channel[5*i +: 5]]
                                               : falling_mask[s_axis_channel[5*i +: 5]]);
            w_n_kept  = w_n_kept + CNT_W'(w_kept[i]);
        end
    end

    always_comb begin
        w_n_pop = '0;
        if (w_pop) begin
            w_n_pop = (r_count >= CNT_W'(W)) ? CNT_W'(W) : r_count;
        end
    end

    assign w_base    = r_count - w_n_pop;
    assign w_count_d = w_base + (w_accept ? w_n_kept : CNT_W'(0));

    // Next buffer: shift out popped entries (zero-fill from the top), then
    // append kept lanes in lane order starting at the post-pop fill level.
    always_comb begin
        logic [CNT_W-1:0] v_pos;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            w_tag_d[j]  = '0;
            w_ch_d[j]   = '0;
            w_rise_d[j] = 1'b0;
        end
        for (int unsigned p = 0; p <= W; p++) begin
            if (w_n_pop == CNT_W'(p)) begin
                for (int unsigned j = 0; j < DEPTH - p; j++) begin
                    w_tag_d[j]  = r_tag[j+p];
                    w_ch_d[j]   = r_ch[j+p];
                    w_rise_d[j] = r_rise[j+p];
                end
            end
        end
        v_pos = w_base;
        for (int unsigned i = 0; i < W; i++) begin
            if (w_accept && w_kept[i]) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (v_pos == CNT_W'(j)) begin
                        w_tag_d[j]  = s_axis_tagtime[64*i +: 64];
                        w_ch_d[j]   = s_axis_channel[5*i +: 5];
                        w_rise_d[j] = s_axis_rising_edge[i];
                    end
                end
                v_pos = v_pos + CNT_W'(1);
            end
        end
    end

    // Idle timer runs only while a partial word waits; zero-kept words do not
    // count as activity. Once flush is pending the input is blocked, so the
    // partial word cannot change until it is handed off.
    assign w_idle_run = (FLUSH_CYCLES != 0) && (r_count != '0) &&
                        (r_count < CNT_W'(W)) && !r_flush;

    always_comb begin
        w_idle_d  = r_idle;
        w_flush_d = r_flush;
        if (w_append || w_pop) begin
            w_idle_d = '0;
        end else if (w_idle_run) begin
            w_idle_d = r_idle + IDLE_W'(1);
        end
        if (w_pop) begin
            w_flush_d = 1'b0;
        end else if (w_idle_run && !w_append && (w_idle_d == IDLE_W'(FLUSH_CYCLES))) begin
            w_flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count       <= '0;
            r_flush       <= 1'b0;
            r_idle        <= '0;
            r_kept_events <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                r_tag[j]  <= '0;
                r_ch[j]   <= '0;
                r_rise[j] <= 1'b0;
            end
        end else begin
            r_count <= w_count_d;
            r_flush <= w_flush_d;
            r_idle  <= w_idle_d;
            if (w_accept) begin
                r_kept_events <= r_kept_events + 32'(w_n_kept);
            end
            for (int unsigned j = 0; j < DEPTH; j++) begin
                r_tag[j]  <= w_tag_d[j];
                r_ch[j]   <= w_ch_d[j];
                r_rise[j] <= w_rise_d[j];
            end
        end
    end

    always_comb begin
        m_axis_tagtime     = '0;
        m_axis_channel     = '0;
        m_axis_rising_edge = '0;
        m_axis_tkeep       = '0;
        for (int unsigned i = 0; i < W; i++) begin
            m_axis_tagtime[64*i +: 64] = r_tag[i];
            m_axis_channel[5*i +: 5]   = r_ch[i];
            m_axis_rising_edge[i]      = r_rise[i];
        end
        if (r_count >= CNT_W'(W)) begin
            m_axis_tkeep = '1;
        end else if (r_flush) begin
            for (int unsigned i = 0; i < W; i++) begin
                m_axis_tkeep[i] = (CNT_W'(i) < r_count);
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tvalid = w_m_valid;
    assign kept_events   = r_kept_events;

endmodule

// File: tb/tb_tag_stream_compactor.sv
module tb_tag_stream_compactor;

    logic         clk;
    logic         rst_n;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [255:0] s_axis_tagtime;
    logic [19:0]  s_axis_channel;
    logic [3:0]   s_axis_rising_edge;
    logic [3:0]   s_axis_tkeep;
    logic [31:0]  rising_mask;
    logic [31:0]  falling_mask;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [255:0] m_axis_tagtime;
    logic [19:0]  m_axis_channel;
    logic [3:0]   m_axis_rising_edge;
    logic [3:0]   m_axis_tkeep;
    logic [31:0]  kept_events;

    int           checks;
    int           errors;
    logic         last_acc;
    logic         rand_rdy;
    logic [31:0]  exp_kept;
    logic [69:0]  exp_q[$];
    logic [69:0]  obs_q[$];

    tag_stream_compactor #(
        .WORD_WIDTH   (4),
        .FLUSH_CYCLES (64)
    ) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tagtime     (s_axis_tagtime),
        .s_axis_channel     (s_axis_channel),
        .s_axis_rising_edge (s_axis_rising_edge),
        .s_axis_tkeep       (s_axis_tkeep),
        .rising_mask        (rising_mask),
        .falling_mask       (falling_mask),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .m_axis_tagtime     (m_axis_tagtime),
        .m_axis_channel     (m_axis_channel),
        .m_axis_rising_edge (m_axis_rising_edge),
        .m_axis_tkeep       (m_axis_tkeep),
        .kept_events        (kept_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic contig(input logic [3:0] k);
        logic [4:0] x;
        x = {1'b0, k} + 5'd1;
        return (k != 4'd0) && ((x[3:0] & k) == 4'd0);
    endfunction

    function automatic logic [255:0] mk_tags(input logic [63:0] base);
        logic [255:0] r;
        for (int i = 0; i < 4; i++) r[64*i +: 64] = base + 64'(i);
        return r;
    endfunction

    // One clock: collect handshaken events, then check hold-while-stalled and
    // that output tkeep is contiguous from lane 0.
    task automatic tick();
        logic         pv, pr, prst;
        logic [255:0] pt;
        logic [19:0]  pc;
        logic [3:0]   pe, pk;
        #1;
        pv   = m_axis_tvalid;
        pr   = m_axis_tready;
        prst = rst_n;
        pt   = m_axis_tagtime;
        pc   = m_axis_channel;
        pe   = m_axis_rising_edge;
        pk   = m_axis_tkeep;
        last_acc = s_axis_tvalid && s_axis_tready;
        if (prst && pv && pr) begin
            for (int i = 0; i < 4; i++)
                if (pk[i]) obs_q.push_back({pe[i], pc[5*i +: 5], pt[64*i +: 64]});
        end
        @(posedge clk);
        #1;
        if (prst && pv && !pr) begin
            chk("hold_valid", 256'(m_axis_tvalid), 256'(1));
            chk("hold_tag", m_axis_tagtime, pt);
            chk("hold_ch", 256'(m_axis_channel), 256'(pc));
            chk("hold_rise", 256'(m_axis_rising_edge), 256'(pe));
            chk("hold_keep", 256'(m_axis_tkeep), 256'(pk));
        end
        if (m_axis_tvalid) chk("keep_contig", 256'(contig(m_axis_tkeep)), 256'(1));
    endtask

    task automatic send_word(input logic [255:0] tags, input logic [19:0] ch,
                             input logic [3:0] rise, input logic [3:0] keep);
        int n;
        logic [4:0] c;
        s_axis_tagtime     = tags;
        s_axis_channel     = ch;
        s_axis_rising_edge = rise;
        s_axis_tkeep       = keep;
        s_axis_tvalid      = 1'b1;
        last_acc = 1'b0;
        n = 0;
        while (!last_acc && n < 100) begin
            if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("accept", 256'(last_acc), 256'(1));
        if (last_acc) begin
            for (int i = 0; i < 4; i++) begin
                c = ch[5*i +: 5];
                if (keep[i] && (rise[i] ? rising_mask[c] : falling_mask[c])) begin
                    exp_q.push_back({rise[i], c, tags[64*i +: 64]});
                    exp_kept = exp_kept + 32'd1;
                end
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic cmp_queues(input string tag);
        chk({tag, "_len"}, 256'(obs_q.size()), 256'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk({tag, "_evt"}, 256'(obs_q[i]), 256'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        checks             = 0;
        errors             = 0;
        rand_rdy           = 1'b0;
        exp_kept           = '0;
        last_acc           = 1'b0;
        rst_n              = 1'b0;
        s_axis_tvalid      = 1'b0;
        s_axis_tagtime     = '0;
        s_axis_channel     = '0;
        s_axis_rising_edge = '0;
        s_axis_tkeep       = '0;
        rising_mask        = 32'hFFFF_FFFF;
        falling_mask       = 32'hFFFF_FFFF;
        m_axis_tready      = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("rst_tkeep", 256'(m_axis_tkeep), 256'(0));
        chk("rst_tagtime", m_axis_tagtime, 256'(0));
        chk("rst_tready", 256'(s_axis_tready), 256'(0));
        chk("rst_kept", 256'(kept_events), 256'(0));
        rst_n = 1'b1;
        tick();
        chk("rel_tready", 256'(s_axis_tready), 256'(1));

        // Compaction: tkeep 0011, 0101, 1000 on channels 0..3, output stalled
        send_word(mk_tags(64'h100), {5'd3, 5'd2, 5'd1, 5'd0}, 4'b1111, 4'b0011);
        chk("w1_tvalid", 256'(m_axis_tvalid), 256'(0));
        send_word(mk_tags(64'h200), {5'd3, 5'd2, 5'd1, 5'd0}, 4'b1111, 4'b0101);
        chk("w2_tvalid", 256'(m_axis_tvalid), 256'(1));
        chk("w2_tkeep", 256'(m_axis_tkeep), 256'(4'b1111));
        chk("w2_tready_at_w", 256'(s_axis_tready), 256'(1));
        chk("w2_tag", m_axis_tagtime, {64'h202, 64'h200, 64'h101, 64'h100});
        send_word(mk_tags(64'h300), {5'd3, 5'd2, 5'd1, 5'd0}, 4'b1111, 4'b1000);
        chk("w3_tready_over_w", 256'(s_axis_tready), 256'(0));
        chk("w3_tag", m_axis_tagtime, {64'h202, 64'h200, 64'h101, 64'h100});
        chk("w3_ch", 256'(m_axis_channel), 256'({5'd2, 5'd0, 5'd1, 5'd0}));
        chk("w3_kept", 256'(kept_events), 256'(5));
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        chk("pop_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("pop_tkeep", 256'(m_axis_tkeep), 256'(0));
        chk("pop_tready", 256'(s_axis_tready), 256'(1));

        // Idle flush of a 2-event partial word
        send_word(mk_tags(64'h400), {5'd5, 5'd5, 5'd5, 5'd5}, 4'b0000, 4'b0001);
        chk("w4_tvalid", 256'(m_axis_tvalid), 256'(0));
        n = 0;
        while (!m_axis_tvalid && n < 200) begin
            tick();
            n++;
        end
        chk("flush_idle_cycles", 256'(n), 256'(64));
        chk("flush_tkeep", 256'(m_axis_tkeep), 256'(4'b0011));
        chk("flush_tag", 256'(m_axis_tagtime[127:0]), {128'd0, 64'h400, 64'h303});
        chk("flush_ch", 256'(m_axis_channel[9:0]), 256'({5'd5, 5'd3}));
        chk("flush_rise", 256'(m_axis_rising_edge[1:0]), 256'(2'b01));
        chk("flush_tready", 256'(s_axis_tready), 256'(0));
        s_axis_tagtime = mk_tags(64'h480);
        s_axis_tkeep   = 4'b1111;
        s_axis_tvalid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush_block", 256'(s_axis_tready), 256'(0));
            chk("flush_no_acc", 256'(last_acc), 256'(0));
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        chk("flush_done_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("flush_done_tkeep", 256'(m_axis_tkeep), 256'(0));
        chk("flush_done_tready", 256'(s_axis_tready), 256'(1));
        chk("t1_kept", 256'(kept_events), 256'(6));
        chk("t1_first", 256'(obs_q.size() > 0 ? obs_q[0][63:0] : 64'hDEAD), 256'(64'h100));
        cmp_queues("t1");

        // Filter: only channel-0 rising events survive
        rising_mask   = 32'h0000_0001;
        falling_mask  = 32'h0000_0000;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [19:0] ch;
            logic [3:0]  rs;
            for (int i = 0; i < 4; i++) begin
                ch[5*i +: 5] = 5'((k + i) & 1);
                rs[i]        = 1'(((k >> 1) ^ i) & 1);
            end
            send_word(mk_tags(64'h1000 + 64'(k * 16)), ch, rs, 4'b1111);
        end
        repeat (3) tick();
        chk("t2_kept", 256'(kept_events), 256'(14));
        chk("t2_count", 256'(obs_q.size()), 256'(8));
        if (obs_q.size() == 8) begin
            chk("t2_first", 256'(obs_q[0]), 256'({1'b1, 5'd0, 64'h1011}));
            chk("t2_last", 256'(obs_q[7]), 256'({1'b1, 5'd0, 64'h1062}));
        end
        cmp_queues("t2");

        // Reset with 6 events buffered discards them
        rising_mask   = 32'hFFFF_FFFF;
        falling_mask  = 32'hFFFF_FFFF;
        m_axis_tready = 1'b0;
        send_word(mk_tags(64'h500), {5'd3, 5'd2, 5'd1, 5'd0}, 4'b1010, 4'b1111);
        send_word(mk_tags(64'h600), {5'd3, 5'd2, 5'd1, 5'd0}, 4'b1010, 4'b0011);
        chk("pre_rst_tready", 256'(s_axis_tready), 256'(0));
        chk("pre_rst_tvalid", 256'(m_axis_tvalid), 256'(1));
        rst_n = 1'b0;
        tick();
        chk("mid_rst_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("mid_rst_tkeep", 256'(m_axis_tkeep), 256'(0));
        chk("mid_rst_tag", m_axis_tagtime, 256'(0));
        chk("mid_rst_ch", 256'(m_axis_channel), 256'(0));
        chk("mid_rst_rise", 256'(m_axis_rising_edge), 256'(0));
        chk("mid_rst_tready", 256'(s_axis_tready), 256'(0));
        chk("mid_rst_kept", 256'(kept_events), 256'(0));
        chk("mid_rst_no_emit", 256'(obs_q.size()), 256'(0));
        exp_q.delete();
        obs_q.delete();
        exp_kept = '0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_tready", 256'(s_axis_tready), 256'(1));
        m_axis_tready = 1'b1;
        send_word(mk_tags(64'h700), {5'd4, 5'd4, 5'd4, 5'd4}, 4'b1111, 4'b1111);
        chk("lat_tvalid", 256'(m_axis_tvalid), 256'(1));
        chk("lat_tag", m_axis_tagtime, {64'h703, 64'h702, 64'h701, 64'h700});
        tick();
        chk("post_rst_kept", 256'(kept_events), 256'(4));
        cmp_queues("post_rst");

        // Randomised masks, lanes and backpressure against the model
        rand_rdy = 1'b1;
        for (int w = 0; w < 1500; w++) begin
            rising_mask  = $urandom;
            falling_mask = $urandom;
            if ($urandom_range(0, 3) == 0) tick();
            send_word({64'hABC0_0000_0000_0000 + 64'(4 * w + 3),
                       64'hABC0_0000_0000_0000 + 64'(4 * w + 2),
                       64'hABC0_0000_0000_0000 + 64'(4 * w + 1),
                       64'hABC0_0000_0000_0000 + 64'(4 * w)},
                      20'($urandom), 4'($urandom), 4'($urandom));
        end
        rand_rdy      = 1'b0;
        m_axis_tready = 1'b1;
        repeat (80) tick();
        chk("rand_kept", 256'(kept_events), 256'(exp_kept));
        chk("rand_drained", 256'(m_axis_tvalid), 256'(0));
        cmp_queues("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tag_stream_compactor.md
# tag_stream_compactor

Upstream stage of the wide user sample consumer: it takes the raw wide tag stream, drops events per a per-channel/per-edge enable mask, and repacks the surviving events into dense words (kept lanes contiguous from lane 0), preserving arrival order. Partially filled words are flushed after a programmable idle timeout. It reduces the number of sparse words seen downstream, and it is the only point in the tag path where backpressure is applied.

## Interface
Parameters:
- WORD_WIDTH, 4, lanes per word (≥2).
- FLUSH_CYCLES, 64, idle cycles before a partial word is emitted; 0 disables flushing.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, synchronous and active-low.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  input word accepted when high with tvalid.
- s_axis_tagtime  in  64×WORD_WIDTH  tag time, 1/3 ps units.
- s_axis_channel  in  5×WORD_WIDTH  zero-based channel.
- s_axis_rising_edge  in  1×WORD_WIDTH  1 = rising, 0 = falling.
- s_axis_tkeep  in  WORD_WIDTH  per-lane event valid.
- rising_mask  in  32  bit c high = keep rising events of channel c.
- falling_mask  in  32  bit c high = keep falling events of channel c.
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake.
- m_axis_tagtime, m_axis_channel, m_axis_rising_edge, m_axis_tkeep  out  same widths as the s_axis_* ports  compacted word.
- kept_events  out  32  wrapping count of events passed through the filter.

## Operation
- Lane i is kept iff s_axis_tkeep[i] & (s_axis_rising_edge[i] ? rising_mask[ch] : falling_mask[ch]). Masks are sampled in the accept cycle; changing them affects only later words.
- Kept lanes are appended, lowest lane first, to an ordered buffer of 2×WORD_WIDTH entries; `count` = number of occupied entries (0..2W).
- The output lanes are buffer entries 0..W-1. The output word is valid when count ≥ W (full word, tkeep all ones) or when flush_pending is set (partial word, tkeep = low `count` bits set).
- On an output handshake: pop min(count, W) entries and shift the remainder down. Push and pop in the same cycle: count_next = count − popped + kept.
- s_axis_tready = rst_n & (count ≤ W) & ~flush_pending. This is registered state only and has no combinational path from m_axis_tready.
- Idle counter: increments while 0 < count < W and no kept lane is appended. It clears on any append or pop. When it reaches FLUSH_CYCLES, flush_pending is set. flush_pending clears on the handshake of the partial word.
- Words with zero kept lanes are accepted and discarded; they do not reset the idle counter.
- kept_events += popcount(kept) on every accept; it wraps at 2^32.
- AXI stability: once m_axis_tvalid is high, the output data and tkeep hold until m_axis_tready. Blocking input while a flush is pending guarantees this.

## Timing
- Accept at cycle t → events visible on m_axis at t+1 if count reaches W. The block adds 1 cycle of latency; there is no combinational path from input to output.
- Throughput: one word per cycle sustained when all lanes are kept and m_axis_tready = 1.
- Reset (rst_n low at a clock edge): count=0, flush_pending=0, idle counter=0, kept_events=0. Outputs from the next edge: m_axis_tvalid=0, m_axis_tkeep=0, m_axis_tagtime=0, m_axis_channel=0, m_axis_rising_edge=0, s_axis_tready=0.
- Reset mid-operation discards buffered events without emitting them. s_axis_tready rises the first cycle after rst_n returns high.
- Boundaries:
  - count = W with m_axis_tready = 0: input still accepted (count up to 2W).
  - count > W: input stalls until a pop.
  - FLUSH_CYCLES = 0: partial words are held indefinitely.

## Test plan
- W=4, all masks 0xFFFFFFFF. Send 3 words with tkeep 0011, 0101, 1000 on channels 0..3 → 1 output word with tagtimes in arrival order and tkeep 1111; 1 event remains buffered. kept_events = 5.
- rising_mask=0x1, falling_mask=0x0. Send 8 full words mixing channel 0/1 rising/falling → only channel-0 rising events appear, in order. kept_events equals their number.
- Set FLUSH_CYCLES=64 and leave 2 events buffered with no further input → m_axis_tvalid on idle cycle 64 with tkeep 0011. s_axis_tready stays 0 until the handshake.
- Hold m_axis_tready=0 and stream full words → s_axis_tready drops once count > 4. Output data stays stable. On release, no event is lost or duplicated (scoreboard check).
- Pull rst_n low for 1 cycle while count=6 → all outputs 0 on the next edge. Post-reset output contains only newly sent events. kept_events restarts from 0.
- Random tkeep, masks and m_axis_tready for 10^5 cycles → output sequence equals the reference-model filtered sequence. Output tkeep is always contiguous from lane 0.
